// File: rtl/case_4_mul_share_pkg.sv
// Shared widths, saturation bounds and stage records for the
// round-robin shared-multiplier scheduler (case_4_mul_share_sched).
package case_4_mul_share_pkg;

    localparam int NUM_REQ    = 4;
    localparam int DIN0_WIDTH = 13;
    localparam int DIN1_WIDTH = 11;
    localparam int DOUT_WIDTH = 14;
    localparam int TAG_WIDTH  = 2;
    localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

    localparam logic signed [PROD_WIDTH-1:0] DOUT_MAX =
        PROD_WIDTH'((2 ** (DOUT_WIDTH - 1)) - 1);
    localparam logic signed [PROD_WIDTH-1:0] DOUT_MIN =
        PROD_WIDTH'(-(2 ** (DOUT_WIDTH - 1)));

    // S1 record: operands waiting for the multiplier
    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DIN0_WIDTH-1:0] a;
        logic [DIN1_WIDTH-1:0] b;
    } s1_rec_t;

    // S2 record: reduced product presented downstream
    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DOUT_WIDTH-1:0] data;
    } s2_rec_t;

endpackage

// File: rtl/case_4_mul_share_if.sv
// Request and result handshake bundle of the shared multiplier.
// master = requesters/downstream side, slave = scheduler side.
interface case_4_mul_share_if
    import case_4_mul_share_pkg::*;
();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_a;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_b;
    logic                          out_valid;
    logic                          out_ready;
    logic [DOUT_WIDTH-1:0]         out_data;
    logic [TAG_WIDTH-1:0]          out_tag;
    logic                          busy;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_data, out_tag, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_data, out_tag, busy
    );

endinterface

// File: rtl/case_4_mul_share_rr_arb.sv
// Combinational round-robin picker: scans from ptr+1 modulo NUM_REQ.
// Ports: req/ptr/en in; one-hot grant and encoded idx out.
module case_4_mul_share_rr_arb
    import case_4_mul_share_pkg::*;
(
    input  logic [NUM_REQ-1:0]   req,
    input  logic [TAG_WIDTH-1:0] ptr,
    input  logic                 en,
    output logic [NUM_REQ-1:0]   grant,
    output logic [TAG_WIDTH-1:0] idx
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (en && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = TAG_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/case_4_mul_share_sched.sv
// Two-stage round-robin scheduler sharing one signed multiplier.
// Ports: ap_clk, ap_rst (sync, active-high), bus (slave modport).
// Macro CASE_4_MUL_SHARE_SAT_EN: saturate instead of wrap.
module case_4_mul_share_sched
    import case_4_mul_share_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst,
    case_4_mul_share_if.slave bus
);

    s1_rec_t s1_q, s1_d;
    s2_rec_t s2_q, s2_d;

    logic [TAG_WIDTH-1:0] rr_q, rr_d;
    logic [TAG_WIDTH-1:0] gnt_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 s1_en, s2_en, hs;

    logic [DIN0_WIDTH-1:0] a_sel;
    logic [DIN1_WIDTH-1:0] b_sel;

    logic signed [DIN0_WIDTH-1:0] sa;
    logic signed [DIN1_WIDTH-1:0] sb;
    logic signed [PROD_WIDTH-1:0] prod;
    logic [DOUT_WIDTH-1:0]        red;

    assign s2_en = !s2_q.valid || bus.out_ready;
    assign s1_en = !s1_q.valid || s2_en;

    case_4_mul_share_rr_arb u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_q),
        .en    (s1_en),
        .grant (grant),
        .idx   (gnt_idx)
    );

    assign bus.req_ready = grant;
    assign hs = |grant;

    assign a_sel =
        bus.req_a[gnt_idx*DIN0_WIDTH +: DIN0_WIDTH];
    assign b_sel =
        bus.req_b[gnt_idx*DIN1_WIDTH +: DIN1_WIDTH];

    assign sa   = s1_q.a;
    assign sb   = s1_q.b;
    assign prod = PROD_WIDTH'(sa) * PROD_WIDTH'(sb);

`ifdef CASE_4_MUL_SHARE_SAT_EN
    always_comb begin
        if (prod > DOUT_MAX) begin
            red = DOUT_MAX[DOUT_WIDTH-1:0];
        end else if (prod < DOUT_MIN) begin
            red = DOUT_MIN[DOUT_WIDTH-1:0];
        end else begin
            red = prod[DOUT_WIDTH-1:0];
        end
    end
`else
    // Modular wrap: upper product bits are dropped on purpose
    logic unused_prod_hi;
    assign unused_prod_hi = ^prod[PROD_WIDTH-1:DOUT_WIDTH];
    assign red = prod[DOUT_WIDTH-1:0];
`endif

    always_comb begin
        s1_d = s1_q;
        if (s1_en) begin
            s1_d.valid = hs;
            if (hs) begin
                s1_d.tag = gnt_idx;
                s1_d.a   = a_sel;
                s1_d.b   = b_sel;
            end
        end
    end

    // Payload only reloads on a real entry to keep out_data quiet
    always_comb begin
        s2_d = s2_q;
        if (s2_en) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.tag  = s1_q.tag;
                s2_d.data = red;
            end
        end
    end

    assign rr_d = hs ? gnt_idx : rr_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_q <= '0;
            s2_q <= '0;
            rr_q <= TAG_WIDTH'(NUM_REQ - 1);
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            rr_q <= rr_d;
        end
    end

    assign bus.out_valid = s2_q.valid;
    assign bus.out_data  = s2_q.data;
    assign bus.out_tag   = s2_q.tag;
    assign bus.busy      = s1_q.valid | s2_q.valid;

endmodule

// File: tb/tb_case_4_mul_share_sched.sv
// Scoreboard bench for case_4_mul_share_sched.
// Issue process pushes expectations, monitor pops on out_valid.
module tb_case_4_mul_share_sched;

    logic ap_clk;
    logic ap_rst;

    case_4_mul_share_if bus ();

    case_4_mul_share_sched dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

`ifdef CASE_4_MUL_SHARE_SAT_EN
    localparam int EXP_B0 = 8191;
    localparam int EXP_B1 = 8191;
    localparam int EXP_B2 = -8192;
`else
    localparam int EXP_B0 = -5119;
    localparam int EXP_B1 = 0;
    localparam int EXP_B2 = 4096;
`endif

    typedef struct {
        logic [1:0]  tag;
        logic [13:0] data;
    } exp_t;

    exp_t sbq[$];

    logic signed [12:0] op_a[4];
    logic signed [10:0] op_b[4];

    int n_pass;
    int n_total;
    int acc;
    int first;
    logic got;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    always_comb begin
        bus.req_a = '0;
        bus.req_b = '0;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*13 +: 13] = op_a[i];
            bus.req_b[i*11 +: 11] = op_b[i];
        end
    end

    function automatic logic [13:0] model(
        logic signed [12:0] a,
        logic signed [10:0] b
    );
        logic signed [23:0] p;
        p = 24'(a) * 24'(b);
`ifdef CASE_4_MUL_SHARE_SAT_EN
        if (p > 24'sd8191) return 14'h1fff;
        if (p < -24'sd8192) return 14'h2000;
`endif
        return p[13:0];
    endfunction

    task automatic chk(
        string name,
        logic signed [31:0] act,
        logic signed [31:0] exp
    );
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d",
                      name, act, exp);
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge ap_clk);
    endtask

    // Issue side: record expected result for every handshake
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            sbq.delete();
        end else begin
            chk("ready_onehot0",
                32'($onehot0(bus.req_ready)), 1);
            chk("ready_within_valid",
                32'(bus.req_ready & ~bus.req_valid), 0);
            for (int i = 0; i < 4; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sbq.push_back('{tag: 2'(i),
                        data: model(op_a[i], op_b[i])});
                end
            end
        end
    end

    // Monitor: presented result must match queue head, also
    // while stalled; pop only on an output handshake
    always @(negedge ap_clk) begin
        if (!ap_rst && bus.out_valid) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL sb_empty: tag %0d data %0d unexpected",
                         bus.out_tag, $signed(bus.out_data));
            end else begin
                chk("sb_tag", 32'(bus.out_tag), 32'(sbq[0].tag));
                chk("sb_data", $signed(bus.out_data),
                    $signed(sbq[0].data));
                if (bus.out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic single(int i, int a, int b, int exp, string nm);
        cyc();
        op_a[i] = 13'(a);
        op_b[i] = 11'(b);
        bus.req_valid = 4'b0001 << i;
        smp();
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'(4'b0001 << i));
        cyc();
        bus.req_valid = '0;
        smp();
        chk({nm, "_busy_t1"}, 32'(bus.busy), 1);
        chk({nm, "_valid_t1"}, 32'(bus.out_valid), 0);
        cyc();
        smp();
        chk({nm, "_valid_t2"}, 32'(bus.out_valid), 1);
        chk({nm, "_data"}, $signed(bus.out_data), exp);
        chk({nm, "_tag"}, 32'(bus.out_tag), i);
        chk({nm, "_busy_t2"}, 32'(bus.busy), 1);
        cyc();
        smp();
        chk({nm, "_idle"}, 32'(bus.busy), 0);
    endtask

    task automatic drain(string nm);
        for (int n = 0; n < 20; n++) begin
            smp();
            if (!bus.busy && sbq.size() == 0) break;
            cyc();
        end
        chk({nm, "_sb_left"}, sbq.size(), 0);
        chk({nm, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        n_total++;
        $display("FAIL timeout: bench did not finish");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        ap_rst = 1'b1;
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        repeat (2) cyc();
        ap_rst = 1'b0;
        smp();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_tag", 32'(bus.out_tag), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);

        single(0, 100, -3, -300, "single");

        cyc();
        ap_rst = 1'b1;
        cyc();
        ap_rst = 1'b0;
        op_a[0] = 7;   op_b[0] = -9;
        op_a[1] = -25; op_b[1] = 40;
        op_a[2] = 300; op_b[2] = 20;
        op_a[3] = -1;  op_b[3] = -1;
        bus.req_valid = 4'hf;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk("rr_grant", 32'(bus.req_ready),
                32'(4'b0001 << rr_exp[k]));
            if (k >= 2) begin
                chk("rr_out_valid", 32'(bus.out_valid), 1);
                chk("rr_out_tag", 32'(bus.out_tag), rr_exp[k-2]);
            end
            cyc();
        end
        bus.req_valid = '0;
        drain("rr");

        single(0, 4095, 1023, EXP_B0, "bnd_max");
        single(1, -4096, -1024, EXP_B1, "bnd_negneg");
        single(2, -4096, 1023, EXP_B2, "bnd_min");

        cyc();
        op_a[1] = -25; op_b[1] = 40;
        op_a[2] = 300; op_b[2] = 20;
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0110;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            smp();
            if (k >= 2) chk("bp_ready_zero", 32'(bus.req_ready), 0);
            acc += $countones(bus.req_ready);
            cyc();
        end
        chk("bp_accepted", acc, 2);
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        bus.req_valid = '0;
        drain("bp");

        cyc();
        bus.req_valid = 4'hf;
        repeat (2) cyc();
        smp();
        chk("mid_pre_busy", 32'(bus.busy), 1);
        chk("mid_pre_valid", 32'(bus.out_valid), 1);
        cyc();
        ap_rst = 1'b1;
        cyc();
        ap_rst = 1'b0;
        smp();
        chk("mid_out_valid", 32'(bus.out_valid), 0);
        chk("mid_busy", 32'(bus.busy), 0);
        chk("mid_first_grant", 32'(bus.req_ready), 1);
        cyc();
        bus.req_valid = '0;
        drain("mid");

        cyc();
        op_a[0] = 1;  op_b[0] = 1;
        op_a[3] = -1; op_b[3] = -1;
        got = 1'b0;
        first = -1;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = {!got, 2'b00, (k % 2 == 0)};
            smp();
            if (!got && bus.req_ready[3]) begin
                got = 1'b1;
                first = k;
            end
            cyc();
        end
        bus.req_valid = '0;
        chk("starve_granted", 32'(got), 1);
        chk("starve_in_time", 32'(first >= 0 && first < 4), 1);
        drain("starve");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
